// File: rtl/uart_mem_loader_pkg.sv
// Shared types and helpers for the serial program loader.
package loader_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    LD_WAIT = 2'd0,
    LD_LOAD = 2'd1,
    LD_PAD  = 2'd2,
    LD_DONE = 2'd3
  } ld_state_t;

  // Byte lanes in stream order: the first byte of a group lands in the MSB lane.
  localparam int LANE0_LSB = 24;
  localparam int LANE1_LSB = 16;
  localparam int LANE2_LSB = 8;
  localparam int LANE3_LSB = 0;

  // Clock cycles per serial bit, rounded to nearest.
  function automatic int bit_cycles(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic int half_cycles(input int clk_hz, input int baud);
    return bit_cycles(clk_hz, baud) / 2;
  endfunction

  // Drop one received byte into its lane of the word being assembled.
  function automatic logic [31:0] pack_byte(input logic [31:0] acc,
                                            input logic [7:0]  b,
                                            input logic [1:0]  idx);
    logic [31:0] w;
    w = acc;
    case (idx)
      2'd0:    w[LANE0_LSB +: 8] = b;
      2'd1:    w[LANE1_LSB +: 8] = b;
      2'd2:    w[LANE2_LSB +: 8] = b;
      default: w[LANE3_LSB +: 8] = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/uart_mem_loader_rx.sv
// UART receiver: 2-flop synchronizer, start/data/stop sampling, byte output.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RX_IDLE  | line idle, waiting for a synchronized falling edge
// RX_START | half a bit in, confirm the start bit is still low
// RX_DATA  | sample 8 data bits one bit period apart, LSB first
// RX_STOP  | sample stop bit; high gives byte_valid, low gives stop_err
module uart_rx
  import loader_pkg::*;
#(
  parameter int BIT_CYC  = 434,
  parameter int HALF_CYC = 217
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_line,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       stop_err
);

  localparam int TW = $clog2(BIT_CYC + 1);

  rx_state_t     state, state_next;
  logic          rx_s1, rx_sync, rx_prev;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          fall, tc;

  assign fall = rx_prev && !rx_sync;
  assign tc   = (timer == '0);

  // Synchronizer; resetting to 0 means a line held low at release never looks like an edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_s1   <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_s1   <= rx_line;
      rx_sync <= rx_s1;
      rx_prev <= rx_sync;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= RX_IDLE;
    else          state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (fall) state_next = RX_START;
      RX_START: if (tc) state_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tc && bit_cnt == 3'd7) state_next = RX_STOP;
      RX_STOP:  if (tc) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  // Bit timer (down-counter), bit counter and data shift register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      timer   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      case (state)
        RX_IDLE: if (fall) timer <= TW'(HALF_CYC - 1);
        RX_START: begin
          if (tc) begin
            timer   <= TW'(BIT_CYC - 1);
            bit_cnt <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        RX_DATA: begin
          if (tc) begin
            shift   <= {rx_sync, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            timer   <= TW'(BIT_CYC - 1);
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: if (!tc) timer <= timer - TW'(1);
      endcase
    end
  end

  // Outputs: one-cycle strobes in the cycle the stop bit is sampled.
  always_comb begin
    rx_byte    = shift;
    byte_valid = (state == RX_STOP) && tc && rx_sync;
    stop_err   = (state == RX_STOP) && tc && !rx_sync;
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Serial program loader: packs UART bytes into 32-bit words, writes them from word 0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// LD_WAIT | no byte seen since reset
// LD_LOAD | loading; idle timeout running, words written as groups fill
// LD_PAD  | zero-padded partial word written, done follows next cycle
// LD_DONE | load ended; held until reset, further bytes ignored
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int ADDR_W      = 12,
  parameter int MAX_WORDS   = 3000,
  parameter int IDLE_CYCLES = 5_000_000
) (
  input  logic              CLOCK_50,
  input  logic              KEY0,
  input  logic              uart_rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              load_busy,
  output logic              load_done,
  output logic              frame_err,
  output logic [ADDR_W-1:0] word_count
);

  localparam int BIT_CYC  = bit_cycles(CLK_HZ, BAUD);
  localparam int HALF_CYC = half_cycles(CLK_HZ, BAUD);
  localparam int IW       = $clog2(IDLE_CYCLES + 1);

  ld_state_t     ld_state, ld_next;
  logic [7:0]    rx_byte;
  logic          byte_valid, stop_err;
  logic [1:0]    byte_idx;
  logic [31:0]   acc;
  logic [IW-1:0] idle_cnt;
  logic          full, accept, timeout;

  uart_rx #(
    .BIT_CYC (BIT_CYC),
    .HALF_CYC(HALF_CYC)
  ) u_rx (
    .clock     (CLOCK_50),
    .reset_n   (KEY0),
    .rx_line   (uart_rx),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .stop_err  (stop_err)
  );

  assign full    = (word_count == ADDR_W'(MAX_WORDS));
  assign accept  = byte_valid &&
                   ((ld_state == LD_WAIT) || ((ld_state == LD_LOAD) && !full));
  // A byte arriving on the terminal cycle wins over the timeout.
  assign timeout = (ld_state == LD_LOAD) && !full && !byte_valid && (idle_cnt == '0);

  // Loader state register.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) ld_state <= LD_WAIT;
    else       ld_state <= ld_next;
  end

  // Loader next-state decode.
  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      LD_WAIT: if (byte_valid) ld_next = LD_LOAD;
      LD_LOAD: begin
        if (full)         ld_next = LD_DONE;
        else if (timeout) ld_next = (byte_idx != 2'd0) ? LD_PAD : LD_DONE;
      end
      LD_PAD:  ld_next = LD_DONE;
      default: ld_next = LD_DONE;
    endcase
  end

  // Loader status outputs.
  always_comb begin
    load_busy = (ld_state == LD_LOAD) || (ld_state == LD_PAD);
    load_done = (ld_state == LD_DONE);
  end

  // Packing, word writes, word counter, idle timeout and sticky frame error.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      frame_err  <= 1'b0;
      byte_idx   <= '0;
      acc        <= '0;
      idle_cnt   <= '0;
    end else begin
      mem_we <= 1'b0;
      if (mem_we) word_count <= word_count + ADDR_W'(1);
      if (stop_err) frame_err <= 1'b1;
      if (accept) begin
        idle_cnt <= IW'(IDLE_CYCLES - 1);
        if (byte_idx == 2'd3) begin
          mem_we    <= 1'b1;
          mem_waddr <= word_count;
          mem_wdata <= pack_byte(acc, rx_byte, byte_idx);
          acc       <= '0;
          byte_idx  <= '0;
        end else begin
          acc      <= pack_byte(acc, rx_byte, byte_idx);
          byte_idx <= byte_idx + 2'd1;
        end
      end else if (timeout) begin
        // Unfilled low lanes are already zero since acc is cleared per word.
        if (byte_idx != 2'd0) begin
          mem_we    <= 1'b1;
          mem_waddr <= word_count;
          mem_wdata <= acc;
          acc       <= '0;
          byte_idx  <= '0;
        end
      end else if ((ld_state == LD_LOAD) && (idle_cnt != '0)) begin
        idle_cnt <= idle_cnt - IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: BIT_CYC=10, IDLE_CYCLES=500; second instance with MAX_WORDS=2.
module tb_uart_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic key0, rx_a, rx_b;

  logic        a_we, a_busy, a_done, a_ferr;
  logic [11:0] a_waddr, a_wc;
  logic [31:0] a_wdata;
  logic        b_we, b_busy, b_done, b_ferr;
  logic [11:0] b_waddr, b_wc;
  logic [31:0] b_wdata;

  uart_mem_loader #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .ADDR_W(12), .MAX_WORDS(3000), .IDLE_CYCLES(500)
  ) dut (
    .CLOCK_50(clk), .KEY0(key0), .uart_rx(rx_a),
    .mem_we(a_we), .mem_waddr(a_waddr), .mem_wdata(a_wdata),
    .load_busy(a_busy), .load_done(a_done), .frame_err(a_ferr), .word_count(a_wc)
  );

  uart_mem_loader #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .ADDR_W(12), .MAX_WORDS(2), .IDLE_CYCLES(500)
  ) dut2 (
    .CLOCK_50(clk), .KEY0(key0), .uart_rx(rx_b),
    .mem_we(b_we), .mem_waddr(b_waddr), .mem_wdata(b_wdata),
    .load_busy(b_busy), .load_done(b_done), .frame_err(b_ferr), .word_count(b_wc)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Write log for each instance, sampled on the falling edge.
  logic [11:0] a_addr_log[64];
  logic [31:0] a_data_log[64];
  int a_wr = 0, a_we_cyc = 0, a_done_cyc = 0;
  logic a_done_q = 1'b0;
  logic [11:0] b_addr_log[64];
  logic [31:0] b_data_log[64];
  int b_wr = 0;

  always @(negedge clk) begin
    if (a_we) begin
      if (a_wr < 64) begin
        a_addr_log[a_wr] = a_waddr;
        a_data_log[a_wr] = a_wdata;
      end
      a_wr++;
      a_we_cyc = cyc;
    end
    if (a_done && !a_done_q) a_done_cyc = cyc;
    a_done_q = a_done;
    if (b_we) begin
      if (b_wr < 64) begin
        b_addr_log[b_wr] = b_waddr;
        b_data_log[b_wr] = b_wdata;
      end
      b_wr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input logic stop_bit);
    set_rx(sel, 1'b0);
    tick(10);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, b[i]);
      tick(10);
    end
    set_rx(sel, stop_bit);
    tick(10);
    set_rx(sel, 1'b1);
    tick(2);
  endtask

  task automatic do_reset();
    key0 = 1'b0;
    tick(3);
    key0 = 1'b1;
    tick(2);
  endtask

  int base;

  initial begin
    key0 = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    tick(3);
    check("rst_we",    {31'd0, a_we},   32'd0);
    check("rst_waddr", {20'd0, a_waddr}, 32'd0);
    check("rst_wdata", a_wdata,          32'd0);
    check("rst_busy",  {31'd0, a_busy}, 32'd0);
    check("rst_done",  {31'd0, a_done}, 32'd0);
    check("rst_ferr",  {31'd0, a_ferr}, 32'd0);
    check("rst_wc",    {20'd0, a_wc},   32'd0);
    key0 = 1'b1;
    tick(3);

    // Single word.
    base = a_wr;
    send(0, 8'h13, 1'b1); send(0, 8'h00, 1'b1); send(0, 8'h00, 1'b1); send(0, 8'h00, 1'b1);
    tick(5);
    check("t1_writes", a_wr - base, 1);
    check("t1_addr",   {20'd0, a_addr_log[base]}, 32'd0);
    check("t1_data",   a_data_log[base], 32'h1300_0000);
    check("t1_wc",     {20'd0, a_wc}, 32'd1);
    check("t1_busy",   {31'd0, a_busy}, 32'd1);
    check("t1_done",   {31'd0, a_done}, 32'd0);

    // Two words.
    do_reset();
    base = a_wr;
    send(0, 8'hB7, 1'b1); send(0, 8'h00, 1'b1); send(0, 8'h10, 1'b1); send(0, 8'h00, 1'b1);
    send(0, 8'h93, 1'b1); send(0, 8'h80, 1'b1); send(0, 8'h10, 1'b1); send(0, 8'h00, 1'b1);
    tick(5);
    check("t2_writes", a_wr - base, 2);
    check("t2_addr0",  {20'd0, a_addr_log[base]}, 32'd0);
    check("t2_data0",  a_data_log[base], 32'hB700_1000);
    check("t2_addr1",  {20'd0, a_addr_log[base+1]}, 32'd1);
    check("t2_data1",  a_data_log[base+1], 32'h9380_1000);
    check("t2_wc",     {20'd0, a_wc}, 32'd2);

    // Bad stop bit, then a good word.
    do_reset();
    base = a_wr;
    send(0, 8'h55, 1'b0);
    send(0, 8'h13, 1'b1); send(0, 8'h00, 1'b1); send(0, 8'h00, 1'b1); send(0, 8'h00, 1'b1);
    tick(5);
    check("t3_ferr",   {31'd0, a_ferr}, 32'd1);
    check("t3_writes", a_wr - base, 1);
    check("t3_addr",   {20'd0, a_addr_log[base]}, 32'd0);
    check("t3_data",   a_data_log[base], 32'h1300_0000);

    // Three-cycle glitch.
    do_reset();
    base = a_wr;
    rx_a = 1'b0;
    tick(3);
    rx_a = 1'b1;
    tick(30);
    check("t4_writes", a_wr - base, 0);
    check("t4_busy",   {31'd0, a_busy}, 32'd0);
    check("t4_ferr",   {31'd0, a_ferr}, 32'd0);
    check("t4_wc",     {20'd0, a_wc}, 32'd0);

    // Partial word padded on timeout, then done.
    do_reset();
    base = a_wr;
    send(0, 8'h01, 1'b1); send(0, 8'h02, 1'b1); send(0, 8'h03, 1'b1); send(0, 8'h04, 1'b1);
    send(0, 8'hAA, 1'b1);
    for (int i = 0; i < 700 && !a_done; i++) tick(1);
    tick(2);
    check("t5_done",     {31'd0, a_done}, 32'd1);
    check("t5_busy",     {31'd0, a_busy}, 32'd0);
    check("t5_writes",   a_wr - base, 2);
    check("t5_data0",    a_data_log[base], 32'h0102_0304);
    check("t5_addr1",    {20'd0, a_addr_log[base+1]}, 32'd1);
    check("t5_data1",    a_data_log[base+1], 32'hAA00_0000);
    check("t5_wc",       {20'd0, a_wc}, 32'd2);
    check("t5_done_lag", a_done_cyc - a_we_cyc, 1);
    send(0, 8'h5A, 1'b1); send(0, 8'h5B, 1'b1); send(0, 8'h5C, 1'b1); send(0, 8'h5D, 1'b1);
    tick(5);
    check("t5_post_writes", a_wr - base, 2);
    check("t5_post_wc",     {20'd0, a_wc}, 32'd2);
    check("t5_post_done",   {31'd0, a_done}, 32'd1);

    // MAX_WORDS=2 instance.
    do_reset();
    base = b_wr;
    send(1, 8'h11, 1'b1); send(1, 8'h22, 1'b1); send(1, 8'h33, 1'b1); send(1, 8'h44, 1'b1);
    send(1, 8'h55, 1'b1); send(1, 8'h66, 1'b1); send(1, 8'h77, 1'b1); send(1, 8'h88, 1'b1);
    send(1, 8'h99, 1'b1);
    tick(5);
    check("t6_writes", b_wr - base, 2);
    check("t6_addr0",  {20'd0, b_addr_log[base]}, 32'd0);
    check("t6_data0",  b_data_log[base], 32'h1122_3344);
    check("t6_addr1",  {20'd0, b_addr_log[base+1]}, 32'd1);
    check("t6_data1",  b_data_log[base+1], 32'h5566_7788);
    check("t6_done",   {31'd0, b_done}, 32'd1);
    check("t6_busy",   {31'd0, b_busy}, 32'd0);
    check("t6_wc",     {20'd0, b_wc}, 32'd2);

    // Reset mid-frame.
    rx_b = 1'b0;
    tick(15);
    key0 = 1'b0;
    tick(2);
    check("t6_rst_we",    {31'd0, b_we},   32'd0);
    check("t6_rst_waddr", {20'd0, b_waddr}, 32'd0);
    check("t6_rst_wdata", b_wdata,          32'd0);
    check("t6_rst_busy",  {31'd0, b_busy}, 32'd0);
    check("t6_rst_done",  {31'd0, b_done}, 32'd0);
    check("t6_rst_ferr",  {31'd0, b_ferr}, 32'd0);
    check("t6_rst_wc",    {20'd0, b_wc},   32'd0);
    rx_b = 1'b1;
    tick(2);
    key0 = 1'b1;
    tick(3);
    base = b_wr;
    send(1, 8'h12, 1'b1); send(1, 8'h34, 1'b1); send(1, 8'h56, 1'b1); send(1, 8'h78, 1'b1);
    tick(5);
    check("t6_re_writes", b_wr - base, 1);
    check("t6_re_addr",   {20'd0, b_addr_log[base]}, 32'd0);
    check("t6_re_data",   b_data_log[base], 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_mem_loader.md
# uart_mem_loader

Serial program loader for the on-board CPU: receives a byte stream over a UART RX line, packs each group of four bytes into a 32-bit word and writes it sequentially into the unified instruction/data memory, starting at word 0. It is the write side of the memory image: the CPU fetch unit is the reader of the same words. It runs on the board clock and replaces the static memory-init file when a new program is downloaded.

## Interface
- CLK_HZ, 50_000_000: input clock frequency.
- BAUD, 115_200: serial bit rate; BIT_CYC = round(CLK_HZ/BAUD), HALF_CYC = BIT_CYC/2.
- ADDR_W, 12: word-address width.
- MAX_WORDS, 3000: memory depth in words; loading stops when reached.
- IDLE_CYCLES, 5_000_000: line-idle timeout that ends a load.

Ports:
- CLOCK_50  in  1  board clock; all logic on its rising edge.
- KEY0  in  1  reset, synchronous, active-low.
- uart_rx  in  1  serial input, idle high, asynchronous to CLOCK_50.
- mem_we  out  1  one-cycle word-write strobe.
- mem_waddr  out  ADDR_W  word address of the write.
- mem_wdata  out  32  word written.
- load_busy  out  1  high from first accepted byte until done.
- load_done  out  1  sticky, high once the load has ended.
- frame_err  out  1  sticky, set on any bad stop bit.
- word_count  out  ADDR_W  number of words written so far.

## Operation
- uart_rx passes through a 2-flop synchronizer; all decisions use the synchronized value.
- RX FSM: IDLE -> START on synchronized falling edge (previous 1, current 0). START: wait HALF_CYC; sample low -> DATA, high -> IDLE (glitch, no byte). DATA: 8 samples, BIT_CYC apart, LSB first. STOP: sample after BIT_CYC; high -> byte valid pulse; low -> frame_err <= 1, byte discarded. Return to IDLE either way.
- Falling-edge detection ensures a line held low at reset release is not taken as a start bit until it has returned high.
- Byte packing: byte index 0..3; first byte of a group -> mem_wdata[31:24], second [23:16], third [15:8], fourth [7:0]. Stream order equals memory-image byte order; the fetch unit performs the little-endian swap.
- Loader FSM: WAIT (busy 0) -> LOAD on first valid byte (busy 1) -> DONE (busy 0, done 1). DONE held until reset; bytes received in DONE are ignored (no write, no count, frame_err still updates).
- On the fourth byte: mem_we = 1 for one cycle with mem_waddr = word_count; word_count increments the following cycle. mem_waddr/mem_wdata stay stable while mem_we is high and hold last values afterwards.
- Timeout: in LOAD, a counter counts cycles since the last valid byte; at IDLE_CYCLES -> DONE. If byte index != 0, the partial word is zero-padded in the unfilled low bytes and written first (one mem_we), then DONE.
- word_count reaching MAX_WORDS -> DONE the cycle after that write's count update.

## Timing
- Reset (KEY0 low at a clock edge): all outputs 0, both FSMs to IDLE/WAIT, byte index 0, counters 0. Reset mid-frame abandons the byte and any partial word.
- Stop-bit sample occurs 2 + HALF_CYC + 9*BIT_CYC cycles after the start edge reaches uart_rx (±1 for synchronizer phase); mem_we asserts the cycle after the fourth byte's stop sample.
- Valid byte and timeout in the same cycle: byte wins, timeout counter reloads.
- Padded-write mem_we and the load_done rise are on consecutive cycles.

## Structure
- Package loader_pkg: RX state and loader state enums, BIT_CYC/HALF_CYC derivation function, byte-lane constants.
- Sub-module uart_rx: synchronizer, RX FSM, bit counter; outputs byte[7:0], byte_valid pulse, stop_err pulse. Packing, addressing, timeout and done logic stay in uart_mem_loader.

## Test plan
Bench uses CLK_HZ=1_000_000, BAUD=100_000 (BIT_CYC=10), IDLE_CYCLES=500.
- Bytes 13 00 00 00 -> one mem_we, waddr 0, wdata 0x13000000, word_count 1, busy 1, done 0.
- Bytes B7 00 10 00 93 80 10 00 -> 0xB7001000 @0, then 0x93801000 @1, word_count 2.
- Byte with stop bit low, then 13 00 00 00 -> frame_err 1, single write 0x13000000 @0.
- uart_rx low for 3 cycles only -> no byte, no write, busy stays 0.
- Four bytes then AA, then 500 idle cycles -> second write 0xAA000000 @1, then done 1, busy 0; further bytes produce no mem_we.
- MAX_WORDS=2: 9 bytes -> two writes, done after the second, ninth byte ignored; KEY0 low mid-frame -> all outputs 0 and next frame loads at addr 0.
